// File: rtl/tt_um_uwasic_onboarding_ihsan_salari_pkg.sv
// Shared constants for the SPI-programmed 16-channel PWM output block:
// register map, frame layout and PWM counter width.
package tt_um_uwasic_onboarding_ihsan_salari_pkg;

    localparam int FRAME_W  = 16;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int PWM_W    = 8;
    localparam int NUM_REGS = 5;
    localparam int CH_W     = 16;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

    // Frame layout: [15] = write flag, [14:8] = address, [7:0] = data.
    function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_W-1:0] f);
        return f[FRAME_W-2:DATA_W];
    endfunction

endpackage

// File: rtl/tt_um_uwasic_onboarding_ihsan_salari_spi_peripheral.sv
// Write-only SPI (mode 0) receiver and the register file it programs.
// Frames are committed on nCS rising only when they are complete, valid writes.
module spi_peripheral #(
    parameter int NUM_REGS = tt_um_uwasic_onboarding_ihsan_salari_pkg::NUM_REGS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        copi,
    input  logic        ncs,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm,
    output logic [7:0]  duty
);
    import tt_um_uwasic_onboarding_ihsan_salari_pkg::*;

    // Count saturates one past a full frame so long frames stay distinguishable.
    localparam logic [4:0] CNT_FULL = 5'(FRAME_W);
    localparam logic [4:0] CNT_LONG = 5'(FRAME_W + 1);

    logic [1:0] sclk_sync;
    logic [1:0] copi_sync;
    logic [1:0] ncs_sync;
    logic       sclk_q;
    logic       ncs_q;

    logic               sclk_s;
    logic               copi_s;
    logic               ncs_s;
    logic               sclk_rise;
    logic               ncs_fall;
    logic               ncs_rise;
    logic               frame_ok;

    logic [FRAME_W-1:0] shift_reg;
    logic [4:0]         bit_cnt;
    logic               commit_valid;
    logic [ADDR_W-1:0]  commit_addr;
    logic [DATA_W-1:0]  commit_data;

    assign sclk_s    = sclk_sync[1];
    assign copi_s    = copi_sync[1];
    assign ncs_s     = ncs_sync[1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign ncs_fall  = ~ncs_s & ncs_q;
    assign ncs_rise  = ncs_s & ~ncs_q;
    assign frame_ok  = (bit_cnt == CNT_FULL) && shift_reg[FRAME_W-1]
                       && (32'(frame_addr(shift_reg)) < NUM_REGS);

    // nCS synchronizer resets high so a held-low nCS is seen as a fresh frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            copi_sync <= 2'b00;
            ncs_sync  <= 2'b11;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            copi_sync <= {copi_sync[0], copi};
            ncs_sync  <= {ncs_sync[0], ncs};
            sclk_q    <= sclk_s;
            ncs_q     <= ncs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            commit_valid <= 1'b0;
            commit_addr  <= '0;
            commit_data  <= '0;
        end else begin
            commit_valid <= 1'b0;
            if (ncs_fall) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (!ncs_s && sclk_rise) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], copi_s};
                if (bit_cnt != CNT_LONG) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (ncs_rise) begin
                commit_valid <= frame_ok;
                commit_addr  <= frame_addr(shift_reg);
                commit_data  <= shift_reg[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out <= '0;
            en_pwm <= '0;
            duty   <= '0;
        end else if (commit_valid) begin
            case (commit_addr)
                ADDR_EN_OUT_LO: en_out[7:0]  <= commit_data;
                ADDR_EN_OUT_HI: en_out[15:8] <= commit_data;
                ADDR_EN_PWM_LO: en_pwm[7:0]  <= commit_data;
                ADDR_EN_PWM_HI: en_pwm[15:8] <= commit_data;
                ADDR_DUTY:      duty         <= commit_data;
                default:        ;
            endcase
        end
    end

endmodule

// File: rtl/tt_um_uwasic_onboarding_ihsan_salari.sv
// Top level: SPI register file plus a free-running 8-bit PWM shared by
// 16 channels, each either static-on, PWM-gated, or off.
module tt_um_uwasic_onboarding_ihsan_salari #(
    parameter int PRESCALE = 13,
    parameter int NUM_REGS = tt_um_uwasic_onboarding_ihsan_salari_pkg::NUM_REGS
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    import tt_um_uwasic_onboarding_ihsan_salari_pkg::*;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    // rst_n is active-high despite its name; it keeps the harness port name.
    logic rst;
    assign rst = rst_n;

    logic [CH_W-1:0]  en_out;
    logic [CH_W-1:0]  en_pwm;
    logic [7:0]       duty;
    logic [PS_W-1:0]  presc;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm;
    logic [CH_W-1:0]  ch_out;

    wire unused = &{ena, uio_in, ui_in[7:3], 1'b0};

    spi_peripheral #(
        .NUM_REGS (NUM_REGS)
    ) u_spi (
        .clk    (clk),
        .rst    (rst),
        .sclk   (ui_in[0]),
        .copi   (ui_in[1]),
        .ncs    (ui_in[2]),
        .en_out (en_out),
        .en_pwm (en_pwm),
        .duty   (duty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (presc == PS_LAST) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            presc   <= presc + 1'b1;
        end
    end

    // Full-scale duty is forced high so 0xFF yields a true 100% level.
    assign pwm    = (duty == 8'hFF) || (pwm_cnt < duty);
    assign ch_out = en_out & (~en_pwm | {CH_W{pwm}});

    assign uo_out  = ch_out[7:0];
    assign uio_out = ch_out[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_ihsan_salari.sv
// Bench for the SPI-programmed PWM block: directed register/PWM scenarios
// followed by random frames, checked against a time-based behavioural model.
module tb_tt_um_uwasic_onboarding_ihsan_salari;

    localparam int PRESCALE = 13;
    localparam int NUM_REGS = 5;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned cyc;
    int          checks;
    int          errors;
    logic [7:0]  m_regs [NUM_REGS];

    tt_um_uwasic_onboarding_ihsan_salari #(
        .PRESCALE (PRESCALE),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .ui_in   ({5'b0, ncs, copi, sclk}),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Clocks elapsed since reset was released; the model derives PWM phase from it.
    always @(posedge clk) begin
        if (rst_n) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #50ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of all 16 channel outputs at the current clock.
    function automatic logic [15:0] model_out();
        logic [15:0] res;
        logic [15:0] eo;
        logic [15:0] ep;
        int          cnt;
        logic        lvl;
        eo  = {m_regs[1], m_regs[0]};
        ep  = {m_regs[3], m_regs[2]};
        cnt = int'((cyc / PRESCALE) % 256);
        lvl = (m_regs[4] == 8'hFF) || (cnt < int'(m_regs[4]));
        for (int i = 0; i < 16; i++) begin
            res[i] = eo[i] && (ep[i] ? lvl : 1'b1);
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    endtask

    // driver tasks
    task automatic spi_bit(input logic b);
        copi = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f, input int nbits);
        logic [6:0] a;
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) spi_bit(f[15 - i]);
            else        spi_bit(1'($urandom_range(0, 1)));
        end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        a = f[14:8];
        if (nbits == 16 && f[15] && int'(a) < NUM_REGS) m_regs[a] = f[7:0];
        repeat (12) @(negedge clk);
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
        send_frame({1'b1, a, d}, 16);
    endtask

    // Compares outputs to the model every clock for ncyc clocks.
    task automatic track(input string tag, input int ncyc);
        int bad;
        bad = 0;
        check_eq({tag, "_now"}, {16'h0, uio_out, uo_out}, {16'h0, model_out()});
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if ({uio_out, uo_out} !== model_out()) bad++;
        end
        check_eq({tag, "_track"}, bad, 0);
    endtask

    task automatic count_high0(input int ncyc, output int highs);
        highs = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (uo_out[0] === 1'b1) highs++;
        end
    endtask

    initial begin
        int         highs;
        int         nb;
        logic [6:0] a;
        logic [7:0] d;

        checks = 0;
        errors = 0;
        ena    = 1'b1;
        uio_in = 8'h00;
        sclk   = 1'b0;
        copi   = 1'b0;
        ncs    = 1'b1;
        rst_n  = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_uo", {24'h0, uo_out}, 32'h00);
        check_eq("rst_uio", {24'h0, uio_out}, 32'h00);
        check_eq("rst_oe", {24'h0, uio_oe}, 32'hFF);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Basic write of en_out low byte
        write_reg(7'h00, 8'hF0);
        check_eq("w0_uo", {24'h0, uo_out}, 32'hF0);
        check_eq("w0_uio", {24'h0, uio_out}, 32'h00);

        // Invalid address, then a read frame: neither has any effect
        write_reg(7'h30, 8'hAA);
        send_frame({1'b0, 7'h00, 8'h55}, 16);
        check_eq("inv_rd_uo", {24'h0, uo_out}, 32'hF0);
        check_eq("inv_rd_uio", {24'h0, uio_out}, 32'h00);

        // Short (8 bit) and long (17 bit) frames are discarded
        send_frame({1'b1, 7'h00, 8'h12}, 8);
        check_eq("short_uo", {24'h0, uo_out}, 32'hF0);
        send_frame({1'b1, 7'h01, 8'h5A}, 17);
        check_eq("long_uio", {24'h0, uio_out}, 32'h00);
        write_reg(7'h05, 8'hFF);
        track("addr5", 50);

        // Channel 0 PWM at 50% duty: 1664 high of every 3328 clocks
        write_reg(7'h00, 8'h01);
        write_reg(7'h02, 8'h01);
        write_reg(7'h04, 8'h80);
        count_high0(256 * PRESCALE, highs);
        check_eq("duty80_high", highs, 1664);
        track("duty80", 512);

        write_reg(7'h04, 8'h00);
        count_high0(256 * PRESCALE, highs);
        check_eq("duty00_high", highs, 0);
        write_reg(7'h04, 8'hFF);
        count_high0(256 * PRESCALE, highs);
        check_eq("dutyFF_high", highs, 256 * PRESCALE);

        // Random frames over all channels, including invalid ones
        for (int n = 0; n < 25; n++) begin
            a = 7'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 7'h30;
            d = 8'($urandom);
            case ($urandom_range(0, 5))
                0:       nb = 8;
                1:       nb = 15;
                2:       nb = 17;
                default: nb = 16;
            endcase
            send_frame({($urandom_range(0, 3) != 0), a, d}, nb);
            track($sformatf("rnd%0d", n), 300);
        end

        // Reset pulse in the middle of a frame aborts it and clears all state
        write_reg(7'h00, 8'hFF);
        write_reg(7'h01, 8'hFF);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) spi_bit(1'b1);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("midrst_uo", {24'h0, uo_out}, 32'h00);
        check_eq("midrst_uio", {24'h0, uio_out}, 32'h00);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) spi_bit(1'b1);
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("after_rst_uo", {24'h0, uo_out}, 32'h00);
        write_reg(7'h01, 8'h3C);
        check_eq("after_rst_uio", {24'h0, uio_out}, 32'h3C);
        track("final", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
